// File: rtl/timer_dev_if.sv
// rtl/timer_dev_if.sv - data-bus responder signals between the M-stage and the timer
interface timer_dev_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic        irq;

    modport master (output addr, we, wdata, input hit, rdata, irq);
    modport slave  (input addr, we, wdata, output hit, rdata, irq);
endinterface

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - memory-mapped countdown timer with CTRL/PRESET/COUNT registers and irq
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    logic [3:0]  ctrl, nxt_ctrl;
    logic [31:0] preset, nxt_preset;
    logic [31:0] count, nxt_count;
    logic [1:0]  state, nxt_state;
    logic        irq_pend, nxt_pend;
    logic        irq_q;
    logic        wr_ctrl, wr_preset;
    logic        auto_reload;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = &{1'b0, bus.addr[1:0]};

    assign bus.hit     = (bus.addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl     = bus.hit & bus.we & (bus.addr[3:2] == 2'd0);
    assign wr_preset   = bus.hit & bus.we & (bus.addr[3:2] == 2'd1);
    // MODE 1x behaves as one-shot
    assign auto_reload = (ctrl[2:1] == 2'b01);

    always_comb begin
        bus.rdata = 32'h0;
        if (bus.hit) begin
            case (bus.addr[3:2])
                2'd0:    bus.rdata = {28'h0, ctrl};
                2'd1:    bus.rdata = preset;
                2'd2:    bus.rdata = count;
                default: bus.rdata = 32'h0;
            endcase
        end
    end

    always_comb begin
        nxt_ctrl   = ctrl;
        nxt_preset = preset;
        nxt_count  = count;
        nxt_state  = state;
        nxt_pend   = irq_pend;
        case (state)
            S_IDLE: if (ctrl[0]) nxt_state = S_LOAD;
            S_LOAD: begin
                nxt_count = preset;
                nxt_state = S_CNT;
            end
            S_CNT: begin
                if (!ctrl[0]) begin
                    nxt_state = S_IDLE;
                end else if (count > 32'd1) begin
                    nxt_count = count - 32'd1;
                end else begin
                    nxt_count = 32'h0;
                    nxt_pend  = 1'b1;
                    nxt_state = S_INT;
                end
            end
            default: begin
                nxt_state = S_IDLE;
                if (auto_reload) nxt_pend    = 1'b0;
                else             nxt_ctrl[0] = 1'b0;
            end
        endcase
        // A CPU write to CTRL overrides whatever the FSM decided this edge
        if (wr_ctrl) begin
            nxt_ctrl = bus.wdata[3:0];
            nxt_pend = 1'b0;
        end
        if (wr_preset) nxt_preset = bus.wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl     <= 4'h0;
            preset   <= 32'h0;
            count    <= 32'h0;
            state    <= S_IDLE;
            irq_pend <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            ctrl     <= nxt_ctrl;
            preset   <= nxt_preset;
            count    <= nxt_count;
            state    <= nxt_state;
            irq_pend <= nxt_pend;
            irq_q    <= nxt_pend & nxt_ctrl[3];
        end
    end

    assign bus.irq = irq_q;
endmodule
